pcs_block_lock_ctrl: RTL

//  64b/66b block-lock state machine (IEEE 802.3 Cl.49 style) sequencing the PCS receive datapath.

---
 rtl/pcs_block_lock_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pcs_block_lock_ctrl.sv
// 64b/66b block-lock controller: hunts sync-header alignment with SLIP pulses, raises BLOCK_SYNC,
// and keeps a saturating lock-loss counter. Includes the two-flop level synchronizer for CSR inputs.

module vi_sync_level #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

module pcs_block_lock_ctrl #(
  parameter int SH_WINDOW = 64,
  parameter int INVLD_MAX = 16,
  parameter int SLIP_WAIT = 4,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CSR_FORCE_LOCK,
  input  logic             CSR_CNT_CLR,
  input  logic [1:0]       DIN_SH,
  input  logic             DIN_EN,
  output logic             SLIP,
  output logic             BLOCK_SYNC,
  output logic [CNT_W-1:0] LOCK_LOSS_CNT,
  output logic [1:0]       STATE
);
  localparam int SHW = $clog2(SH_WINDOW + 1);
  localparam int IVW = $clog2(INVLD_MAX + 1);
  localparam int WTW = $clog2(SLIP_WAIT + 1);
  localparam logic [SHW-1:0] SH_LAST   = SHW'(SH_WINDOW - 1);
  localparam logic [IVW-1:0] INVLD_LST = IVW'(INVLD_MAX - 1);
  localparam logic [WTW-1:0] WAIT_LAST = WTW'(SLIP_WAIT - 1);

  typedef enum logic [1:0] {
    RESET_CNT = 2'd0,
    TEST_SH   = 2'd1,
    SLIP_WT   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [SHW-1:0]   sh_cnt, sh_nxt;
  logic [IVW-1:0]   invld_cnt, invld_nxt;
  logic [WTW-1:0]   wait_cnt, wait_nxt;
  logic             block_lock, lock_nxt;
  logic             slip_q, slip_nxt;
  logic             loss;
  logic [CNT_W-1:0] loss_cnt, loss_cnt_nxt;
  logic [1:0]       csr_s;
  logic             force_s, clr_s, hdr_ok;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  vi_sync_level #(.W(2)) u_csr_sync (
    .clk   (CLK),
    .rst_n (~RST),
    .d     ({CSR_CNT_CLR, CSR_FORCE_LOCK}),
    .q     (csr_s)
  );

  assign force_s = csr_s[0];
  assign clr_s   = csr_s[1];
  assign hdr_ok  = (DIN_SH == 2'b01) || (DIN_SH == 2'b10);

  always_comb begin
    state_nxt = state;
    sh_nxt    = sh_cnt;
    invld_nxt = invld_cnt;
    wait_nxt  = wait_cnt;
    lock_nxt  = block_lock;
    slip_nxt  = 1'b0;
    loss      = 1'b0;
    if (force_s) begin
      // Forced lock parks the hunt; releasing it starts a fresh, unlocked search.
      state_nxt = RESET_CNT;
      sh_nxt    = '0;
      invld_nxt = '0;
      wait_nxt  = '0;
      lock_nxt  = 1'b0;
    end else begin
      case (state)
        RESET_CNT: begin
          sh_nxt    = '0;
          invld_nxt = '0;
          state_nxt = TEST_SH;
        end
        TEST_SH: begin
          if (DIN_EN) begin
            sh_nxt = sh_cnt + 1'b1;
            if (!hdr_ok) invld_nxt = invld_cnt + 1'b1;
            // Lock loss is checked before the window end so a coincident 64th beat loses lock.
            if (!hdr_ok && !block_lock) begin
              state_nxt = SLIP_WT;
              slip_nxt  = 1'b1;
            end else if (!hdr_ok && invld_cnt == INVLD_LST) begin
              lock_nxt  = 1'b0;
              loss      = 1'b1;
              state_nxt = SLIP_WT;
              slip_nxt  = 1'b1;
            end else if (sh_cnt == SH_LAST) begin
              if (invld_cnt == '0 && hdr_ok) lock_nxt = 1'b1;
              state_nxt = RESET_CNT;
            end
          end
        end
        SLIP_WT: begin
          if (DIN_EN) begin
            if (wait_cnt == WAIT_LAST) begin
              wait_nxt  = '0;
              state_nxt = RESET_CNT;
            end else begin
              wait_nxt = wait_cnt + 1'b1;
            end
          end
        end
        default: state_nxt = RESET_CNT;
      endcase
    end
  end

  always_comb begin
    loss_cnt_nxt = loss_cnt;
    if (clr_s)     loss_cnt_nxt = '0;
    else if (loss) loss_cnt_nxt = sat_inc(loss_cnt);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= RESET_CNT;
      sh_cnt     <= '0;
      invld_cnt  <= '0;
      wait_cnt   <= '0;
      block_lock <= 1'b0;
      slip_q     <= 1'b0;
      loss_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      sh_cnt     <= sh_nxt;
      invld_cnt  <= invld_nxt;
      wait_cnt   <= wait_nxt;
      block_lock <= lock_nxt;
      slip_q     <= slip_nxt;
      loss_cnt   <= loss_cnt_nxt;
    end
  end

  assign SLIP          = slip_q;
  assign BLOCK_SYNC    = block_lock | force_s;
  assign LOCK_LOSS_CNT = loss_cnt;
  assign STATE         = state;
endmodule
